// File: rtl/vx_csr_access_ctrl.sv
// CSR access initiator: serialises CSRRW/RS/RC (and immediate forms) into one
// read, an optional write, and a single response carrying the old CSR value.
module vx_csr_access_ctrl #(
  parameter int NUM_WARPS     = 4,
  parameter int NUM_THREADS   = 4,
  parameter int UUID_BITS     = 44,
  parameter int CSR_ADDR_BITS = 12,
  localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and rsp_valid holds its fields until taken.
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [UUID_BITS-1:0]     req_uuid,
  input  logic [NW_BITS-1:0]       req_wid,
  input  logic [NUM_THREADS-1:0]   req_tmask,
  input  logic [1:0]               req_op,
  input  logic                     req_use_imm,
  input  logic [4:0]               req_imm,
  input  logic                     req_rs1_x0,
  input  logic [31:0]              req_rs1_data,
  input  logic [CSR_ADDR_BITS-1:0] req_addr,
  input  logic [4:0]               req_rd,
  input  logic                     req_wb,
  output logic                     read_enable,
  output logic [UUID_BITS-1:0]     read_uuid,
  output logic [CSR_ADDR_BITS-1:0] read_addr,
  output logic [NW_BITS-1:0]       read_wid,
  input  logic [31:0]              read_data,
  output logic                     write_enable,
  output logic [UUID_BITS-1:0]     write_uuid,
  output logic [CSR_ADDR_BITS-1:0] write_addr,
  output logic [NW_BITS-1:0]       write_wid,
  output logic [31:0]              write_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [UUID_BITS-1:0]     rsp_uuid,
  output logic [NW_BITS-1:0]       rsp_wid,
  output logic [NUM_THREADS-1:0]   rsp_tmask,
  output logic [4:0]               rsp_rd,
  output logic                     rsp_wb,
  output logic [31:0]              rsp_data,
  output logic                     busy,
  output logic [63:0]              csr_stalls,
  output logic [1:0]               o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RSP   = 2'd3
  } state_t;

  localparam logic [1:0] OP_RW = 2'd0;
  localparam logic [1:0] OP_RS = 2'd1;
  localparam logic [1:0] OP_RC = 2'd2;

  state_t                   r_state, w_next;
  logic [UUID_BITS-1:0]     r_uuid;
  logic [NW_BITS-1:0]       r_wid;
  logic [NUM_THREADS-1:0]   r_tmask;
  logic [1:0]               r_op;
  logic                     r_use_imm;
  logic [4:0]               r_imm;
  logic                     r_rs1_x0;
  logic [31:0]              r_rs1_data;
  logic [CSR_ADDR_BITS-1:0] r_addr;
  logic [4:0]               r_rd;
  logic                     r_wb;
  logic [31:0]              r_old;
  logic [31:0]              r_new;
  logic [63:0]              r_stalls;

  logic [31:0] w_src;
  logic [31:0] w_new;
  logic        w_op_valid;
  logic        w_do_read;
  logic        w_do_write;

  assign w_src      = r_use_imm ? {27'b0, r_imm} : r_rs1_data;
  assign w_op_valid = (r_op != 2'd3);
  // CSRRW with rd=x0 must not read; set/clear with a zero source must not write.
  assign w_do_read  = w_op_valid && !((r_op == OP_RW) && !r_wb);
  assign w_do_write = w_op_valid &&
                      ((r_op == OP_RW) || !(r_use_imm ? (r_imm == 5'd0) : r_rs1_x0));

  always_comb begin
    w_new = 32'd0;
    case (r_op)
      OP_RW:   w_new = w_src;
      OP_RS:   w_new = read_data | w_src;
      OP_RC:   w_new = read_data & ~w_src;
      default: w_new = 32'd0;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = !reset;
        if (req_valid) w_next = S_READ;
      end
      S_READ: begin
        read_enable = w_do_read && !reset;
        w_next      = w_do_write ? S_WRITE : S_RSP;
      end
      S_WRITE: begin
        write_enable = !reset;
        w_next       = S_RSP;
      end
      S_RSP: begin
        rsp_valid = !reset;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_uuid     <= '0;
      r_wid      <= '0;
      r_tmask    <= '0;
      r_op       <= '0;
      r_use_imm  <= 1'b0;
      r_imm      <= '0;
      r_rs1_x0   <= 1'b0;
      r_rs1_data <= '0;
      r_addr     <= '0;
      r_rd       <= '0;
      r_wb       <= 1'b0;
      r_old      <= '0;
      r_new      <= '0;
      r_stalls   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && req_valid) begin
        r_uuid     <= req_uuid;
        r_wid      <= req_wid;
        r_tmask    <= req_tmask;
        r_op       <= req_op;
        r_use_imm  <= req_use_imm;
        r_imm      <= req_imm;
        r_rs1_x0   <= req_rs1_x0;
        r_rs1_data <= req_rs1_data;
        r_addr     <= req_addr;
        r_rd       <= req_rd;
        r_wb       <= req_wb;
      end
      if (r_state == S_READ) begin
        r_old <= read_enable ? read_data : 32'd0;
        r_new <= w_new;
      end
      if (req_valid && !req_ready) r_stalls <= r_stalls + 64'd1;
    end
  end

  assign read_uuid   = r_uuid;
  assign read_addr   = r_addr;
  assign read_wid    = r_wid;
  assign write_uuid  = r_uuid;
  assign write_addr  = r_addr;
  assign write_wid   = r_wid;
  assign write_data  = r_new;
  assign rsp_uuid    = r_uuid;
  assign rsp_wid     = r_wid;
  assign rsp_tmask   = r_tmask;
  assign rsp_rd      = r_rd;
  assign rsp_wb      = r_wb;
  assign rsp_data    = r_old;
  assign busy        = (r_state != S_IDLE) && !reset;
  assign csr_stalls  = r_stalls;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vx_csr_access_ctrl.sv
// Directed bench for vx_csr_access_ctrl with a small CSR memory behind the
// read/write port; expected values are hand-computed per vector.
module tb_vx_csr_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [43:0] req_uuid;
  logic [1:0]  req_wid;
  logic [3:0]  req_tmask;
  logic [1:0]  req_op;
  logic        req_use_imm;
  logic [4:0]  req_imm;
  logic        req_rs1_x0;
  logic [31:0] req_rs1_data;
  logic [11:0] req_addr;
  logic [4:0]  req_rd;
  logic        req_wb;
  logic        read_enable;
  logic [43:0] read_uuid;
  logic [11:0] read_addr;
  logic [1:0]  read_wid;
  logic [31:0] read_data;
  logic        write_enable;
  logic [43:0] write_uuid;
  logic [11:0] write_addr;
  logic [1:0]  write_wid;
  logic [31:0] write_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [43:0] rsp_uuid;
  logic [1:0]  rsp_wid;
  logic [3:0]  rsp_tmask;
  logic [4:0]  rsp_rd;
  logic        rsp_wb;
  logic [31:0] rsp_data;
  logic        busy;
  logic [63:0] csr_stalls;
  logic [1:0]  o_dbg_state;

  vx_csr_access_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid),
    .req_wid(req_wid), .req_tmask(req_tmask), .req_op(req_op),
    .req_use_imm(req_use_imm), .req_imm(req_imm), .req_rs1_x0(req_rs1_x0),
    .req_rs1_data(req_rs1_data), .req_addr(req_addr), .req_rd(req_rd),
    .req_wb(req_wb),
    .read_enable(read_enable), .read_uuid(read_uuid), .read_addr(read_addr),
    .read_wid(read_wid), .read_data(read_data),
    .write_enable(write_enable), .write_uuid(write_uuid),
    .write_addr(write_addr), .write_wid(write_wid), .write_data(write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid),
    .rsp_wid(rsp_wid), .rsp_tmask(rsp_tmask), .rsp_rd(rsp_rd),
    .rsp_wb(rsp_wb), .rsp_data(rsp_data),
    .busy(busy), .csr_stalls(csr_stalls), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // CSR memory model with a bench-side preload port
  logic [31:0] csr_mem [0:4095];
  logic        tb_we;
  logic [11:0] tb_waddr;
  logic [31:0] tb_wdata;

  assign read_data = csr_mem[read_addr];

  always @(posedge clk) begin
    if (tb_we) csr_mem[tb_waddr] <= tb_wdata;
    else if (write_enable) csr_mem[write_addr] <= write_data;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic [43:0] cur_uuid = 44'h100;
  logic [1:0]  exp_wid;
  logic [3:0]  exp_tmask;
  logic [4:0]  exp_rd;
  logic        exp_wb;

  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = addr; tb_wdata = data;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic use_imm, input logic [4:0] imm,
                           input logic rs1_x0, input logic [31:0] rs1,
                           input logic [11:0] addr, input logic wb);
    cur_uuid     = cur_uuid + 44'd1;
    exp_wid      = cur_uuid[1:0];
    exp_tmask    = cur_uuid[3:0] | 4'b0001;
    exp_rd       = cur_uuid[4:0] + 5'd3;
    exp_wb       = wb;
    req_uuid     = cur_uuid;
    req_wid      = exp_wid;
    req_tmask    = exp_tmask;
    req_rd       = exp_rd;
    req_op       = op;
    req_use_imm  = use_imm;
    req_imm      = imm;
    req_rs1_x0   = rs1_x0;
    req_rs1_data = rs1;
    req_addr     = addr;
    req_wb       = wb;
    req_valid    = 1'b1;
  endtask

  // Drives a request for one cycle (cycle 0) and returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] op, input logic use_imm, input logic [4:0] imm,
                       input logic rs1_x0, input logic [31:0] rs1,
                       input logic [11:0] addr, input logic wb);
    @(negedge clk);
    drive_req(op, use_imm, imm, rs1_x0, rs1, addr, wb);
    #1 chk("req_ready_c0", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic use_imm, input logic [4:0] imm,
                        input logic rs1_x0, input logic [31:0] rs1,
                        input logic [11:0] addr, input logic wb,
                        input logic exp_read, input logic exp_write,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rsp);
    issue(op, use_imm, imm, rs1_x0, rs1, addr, wb);
    chk("c1_read_en", {63'd0, read_enable}, {63'd0, exp_read});
    chk("c1_write_en", {63'd0, write_enable}, 64'd0);
    chk("c1_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("c1_busy", {63'd0, busy}, 64'd1);
    chk("c1_state", {62'd0, o_dbg_state}, 64'd1);
    if (exp_read) begin
      chk("c1_read_addr", {52'd0, read_addr}, {52'd0, addr});
      chk("c1_read_uuid", {20'd0, read_uuid}, {20'd0, cur_uuid});
      chk("c1_read_wid", {62'd0, read_wid}, {62'd0, exp_wid});
    end
    if (exp_write) begin
      @(negedge clk);
      chk("c2_write_en", {63'd0, write_enable}, 64'd1);
      chk("c2_write_data", {32'd0, write_data}, {32'd0, exp_wdata});
      chk("c2_write_addr", {52'd0, write_addr}, {52'd0, addr});
      chk("c2_write_uuid", {20'd0, write_uuid}, {20'd0, cur_uuid});
      chk("c2_read_en", {63'd0, read_enable}, 64'd0);
      chk("c2_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    end
    @(negedge clk);
    chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("rsp_data", {32'd0, rsp_data}, {32'd0, exp_rsp});
    chk("rsp_uuid", {20'd0, rsp_uuid}, {20'd0, cur_uuid});
    chk("rsp_wid", {62'd0, rsp_wid}, {62'd0, exp_wid});
    chk("rsp_tmask", {60'd0, rsp_tmask}, {60'd0, exp_tmask});
    chk("rsp_rd", {59'd0, rsp_rd}, {59'd0, exp_rd});
    chk("rsp_wb", {63'd0, rsp_wb}, {63'd0, exp_wb});
    chk("rsp_write_en", {63'd0, write_enable}, 64'd0);
    @(negedge clk);
    chk("post_busy", {63'd0, busy}, 64'd0);
    chk("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("post_req_ready", {63'd0, req_ready}, 64'd1);
  endtask

  logic [43:0] first_uuid;

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; tb_we = 1'b0;
    tb_waddr = '0; tb_wdata = '0;
    drive_req(2'd0, 1'b0, 5'd0, 1'b0, 32'd0, 12'd0, 1'b0);
    req_valid = 1'b0;
    cur_uuid  = 44'h100;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_read_en", {63'd0, read_enable}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_state", {62'd0, o_dbg_state}, 64'd0);
    chk("rst_stalls", csr_stalls, 64'd0);
    chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // CSRRS: 0xF0 | 0x0F
    preload(12'h100, 32'h0000_00F0);
    run_op(2'd1, 1'b0, 5'd0, 1'b0, 32'h0F, 12'h100, 1'b1, 1'b1, 1'b1, 32'hFF, 32'hF0);
    // CSRRCI imm=0: read only
    preload(12'h101, 32'h55);
    run_op(2'd2, 1'b1, 5'd0, 1'b0, 32'hFFFF_FFFF, 12'h101, 1'b1, 1'b1, 1'b0, 32'd0, 32'h55);
    // CSRRW rd=x0: write only, old value reported as 0
    preload(12'h102, 32'h777);
    run_op(2'd0, 1'b0, 5'd0, 1'b0, 32'h1234, 12'h102, 1'b0, 1'b0, 1'b1, 32'h1234, 32'd0);
    chk("mem_after_rw", {32'd0, csr_mem[12'h102]}, 64'h1234);
    // CSRRC: 0xFF & ~0x0F
    run_op(2'd2, 1'b0, 5'd0, 1'b0, 32'h0F, 12'h100, 1'b1, 1'b1, 1'b1, 32'hF0, 32'hFF);
    // CSRRSI imm=0x0A: 0x55 | 0x0A
    run_op(2'd1, 1'b1, 5'h0A, 1'b0, 32'hDEAD_0000, 12'h101, 1'b1, 1'b1, 1'b1, 32'h5F, 32'h55);
    // reserved op: response only
    run_op(2'd3, 1'b0, 5'd0, 1'b0, 32'hFFFF, 12'h100, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    // CSRRS with rs1=x0: read only, rs1 data ignored
    run_op(2'd1, 1'b0, 5'd0, 1'b1, 32'hFFFF, 12'h100, 1'b1, 1'b1, 1'b0, 32'd0, 32'hF0);

    // Response backpressure with a queued request
    preload(12'h340, 32'h0F0F);
    chk("stall_start", csr_stalls, 64'd0);
    rsp_ready = 1'b0;
    issue(2'd1, 1'b0, 5'd0, 1'b0, 32'hF0, 12'h340, 1'b1);
    first_uuid = cur_uuid;
    @(negedge clk);
    @(negedge clk);
    drive_req(2'd1, 1'b0, 5'd0, 1'b1, 32'h0, 12'h340, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("hold_rsp_data", {32'd0, rsp_data}, 64'h0F0F);
      chk("hold_rsp_uuid", {20'd0, rsp_uuid}, {20'd0, first_uuid});
      chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
      chk("hold_stalls", csr_stalls, 64'(k));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("hs_stalls", csr_stalls, 64'd5);
    @(negedge clk);
    chk("after_hs_req_ready", {63'd0, req_ready}, 64'd1);
    chk("after_hs_stalls", csr_stalls, 64'd6);
    @(negedge clk);
    req_valid = 1'b0;
    chk("q_read_en", {63'd0, read_enable}, 64'd1);
    chk("q_read_uuid", {20'd0, read_uuid}, {20'd0, cur_uuid});
    @(negedge clk);
    chk("q_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("q_rsp_data", {32'd0, rsp_data}, 64'h0FFF);
    @(negedge clk);
    chk("q_stalls_final", csr_stalls, 64'd6);

    // Reset arriving in WRITE
    preload(12'h200, 32'h3C);
    issue(2'd0, 1'b0, 5'd0, 1'b0, 32'h99, 12'h200, 1'b1);
    @(negedge clk);
    chk("wr_state", {62'd0, o_dbg_state}, 64'd2);
    chk("wr_en_before_rst", {63'd0, write_enable}, 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_wr_write_en", {63'd0, write_enable}, 64'd0);
    chk("rst_wr_busy", {63'd0, busy}, 64'd0);
    chk("rst_wr_stalls_pre", csr_stalls, 64'd6);
    @(negedge clk);
    chk("rst_wr_state", {62'd0, o_dbg_state}, 64'd0);
    chk("rst_wr_stalls", csr_stalls, 64'd0);
    chk("rst_wr_mem", {32'd0, csr_mem[12'h200]}, 64'h3C);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wr_no_rsp", {63'd0, rsp_valid}, 64'd0);
    chk("rst_wr_idle_busy", {63'd0, busy}, 64'd0);
    chk("rst_wr_req_ready", {63'd0, req_ready}, 64'd1);

    // Back-to-back on one CSR: second access sees the first write
    preload(12'h300, 32'h11);
    run_op(2'd0, 1'b0, 5'd0, 1'b0, 32'hAA, 12'h300, 1'b1, 1'b1, 1'b1, 32'hAA, 32'h11);
    run_op(2'd1, 1'b0, 5'd0, 1'b0, 32'h01, 12'h300, 1'b1, 1'b1, 1'b1, 32'hAB, 32'hAA);
    chk("b2b_mem", {32'd0, csr_mem[12'h300]}, 64'hAB);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
